// File: rtl/ahb_sram_slave.sv
// AHB-Lite SRAM responder: word-organised memory with little-endian byte lanes,
// a configurable number of wait states per OKAY data phase, and a two-cycle ERROR response.
module ahb_sram_slave #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int WAIT_STATES = 0
) (
  input  logic                  HCLK,
  input  logic                  HRESET,
  input  logic                  HSEL,
  input  logic [ADDR_WIDTH-1:0] HADDR,
  input  logic [1:0]            HTRANS,
  input  logic                  HWRITE,
  input  logic [2:0]            HSIZE,
  input  logic [DATA_WIDTH-1:0] HWDATA,
  input  logic                  HREADY,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic                  HREADYOUT,
  output logic                  HRESP,
  output logic [1:0]            dbg_state
);

  localparam int IDX_W = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_WIDTH-1:0] MEM_BYTES = ADDR_WIDTH'(4 * MEM_DEPTH);
  localparam logic [3:0] WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ERR1, S_ERR2} state_t;

  state_t                state, state_n;
  logic [3:0]            cnt, cnt_n;
  logic                  dp_ok;
  logic                  cap_write;
  logic [1:0]            cap_size;
  logic [1:0]            cap_lo;
  logic [IDX_W-1:0]      cap_idx;
  logic [3:0]            be;
  logic                  accept;
  logic                  addr_err;
  logic                  complete;
  logic                  unused_trans;
  logic [DATA_WIDTH-1:0] mem [MEM_DEPTH];

  // Handshake: an address phase is taken at a rising edge when HSEL, HREADY and
  // HTRANS[1] are all high; the data phase it opens ends at the first later edge
  // where HREADYOUT is high. Only IDLE/ERR2 can take one, since HREADY is low otherwise.
  assign accept = HSEL && HREADY && HTRANS[1] && (state == S_IDLE || state == S_ERR2);

  assign addr_err = (HADDR >= MEM_BYTES) ||
                    (HSIZE > 3'b010) ||
                    (HSIZE == 3'b001 && HADDR[0]) ||
                    (HSIZE == 3'b010 && HADDR[1:0] != 2'b00);

  // OKAY data phase whose final (ready-high) cycle is the current one.
  assign complete = dp_ok && (state == S_IDLE);

  assign unused_trans = HTRANS[0];
  assign dbg_state    = state;

  always_comb begin
    state_n   = state;
    cnt_n     = cnt;
    HREADYOUT = 1'b1;
    HRESP     = 1'b0;
    case (state)
      S_WAIT: begin
        HREADYOUT = 1'b0;
        cnt_n     = cnt - 4'd1;
        if (cnt == 4'd1) state_n = S_IDLE;
      end
      S_ERR1: begin
        HREADYOUT = 1'b0;
        HRESP     = 1'b1;
        state_n   = S_ERR2;
      end
      default: begin
        HRESP   = (state == S_ERR2);
        state_n = S_IDLE;
        if (accept) begin
          if (addr_err) begin
            state_n = S_ERR1;
          end else if (WAIT_STATES != 0) begin
            state_n = S_WAIT;
            cnt_n   = WS;
          end
        end
      end
    endcase
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state     <= S_IDLE;
      cnt       <= '0;
      dp_ok     <= 1'b0;
      cap_write <= 1'b0;
      cap_size  <= '0;
      cap_lo    <= '0;
      cap_idx   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
      if (accept) begin
        dp_ok     <= !addr_err;
        cap_write <= HWRITE;
        cap_size  <= HSIZE[1:0];
        cap_lo    <= HADDR[1:0];
        cap_idx   <= HADDR[IDX_W+1:2];
      end else if (complete) begin
        dp_ok <= 1'b0;
      end
    end
  end

  always_comb begin
    be = 4'b1111;
    case (cap_size)
      2'b00:   be = 4'b0001 << cap_lo;
      2'b01:   be = cap_lo[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
  end

  // Write commits only at the completion edge, so a reset during wait states drops it.
  always_ff @(posedge HCLK) begin
    if (!HRESET && complete && cap_write) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[cap_idx][8*b +: 8] <= HWDATA[8*b +: 8];
      end
    end
  end

  assign HRDATA = (dp_ok && !cap_write) ? mem[cap_idx] : '0;

endmodule

// File: tb/tb_ahb_sram_slave.sv
// Bench for ahb_sram_slave: one instance with zero wait states and one with two,
// driven by a pipelined AHB-Lite master task and checked by a per-cycle response monitor.
module tb_ahb_sram_slave;

  logic        HCLK = 1'b0;
  logic        HRESET;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready_en;
  int          cur;

  logic [31:0] rdata0, rdata2;
  logic        ro0, ro2, resp0, resp2;
  logic [1:0]  dbg0, dbg2;
  logic        hsel0, hsel2, hready0, hready2;

  assign hsel0   = hsel && (cur == 0);
  assign hsel2   = hsel && (cur == 2);
  assign hready0 = ro0 && hready_en;
  assign hready2 = ro2 && hready_en;

  logic [31:0] rdata_m;
  logic        ready_m, resp_m, hready_m;
  int          ws_m;
  assign rdata_m  = (cur == 2) ? rdata2 : rdata0;
  assign ready_m  = (cur == 2) ? ro2 : ro0;
  assign resp_m   = (cur == 2) ? resp2 : resp0;
  assign hready_m = (cur == 2) ? hready2 : hready0;
  assign ws_m     = (cur == 2) ? 2 : 0;

  ahb_sram_slave #(.WAIT_STATES(0)) dut0 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel0), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready0),
    .HRDATA(rdata0), .HREADYOUT(ro0), .HRESP(resp0), .dbg_state(dbg0)
  );

  ahb_sram_slave #(.WAIT_STATES(2)) dut2 (
    .HCLK(HCLK), .HRESET(HRESET), .HSEL(hsel2), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready2),
    .HRDATA(rdata2), .HREADYOUT(ro2), .HRESP(resp2), .dbg_state(dbg2)
  );

  // ---------------- clock / reset ----------------
  initial forever #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int          n_checks = 0;
  int          n_fail   = 0;
  logic [33:0] exp_q[$];     // {err, write, read data}
  logic [33:0] cur_exp;
  logic        in_dp = 1'b0;
  int          k = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic check1(input string name, input logic act, input logic exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge HCLK) begin
    if (in_dp) begin
      if (cur_exp[33]) begin
        check1("err_ready", ready_m, (k != 0));
        check1("err_resp", resp_m, 1'b1);
        check("err_rdata", rdata_m, 32'h0);
      end else begin
        check1("ok_ready", ready_m, (k == ws_m));
        check1("ok_resp", resp_m, 1'b0);
        check("rdata", rdata_m, cur_exp[32] ? 32'h0 : cur_exp[31:0]);
      end
    end else begin
      check1("idle_ready", ready_m, 1'b1);
      check1("idle_resp", resp_m, 1'b0);
      check("idle_rdata", rdata_m, 32'h0);
    end
    if (HRESET) begin
      in_dp = 1'b0;
      exp_q.delete();
    end else begin
      if (in_dp && hready_m) in_dp = 1'b0;
      else if (in_dp) k++;
      if (hsel && hready_m && htrans[1]) begin
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_accept: transfer taken with empty queue (t=%0t)", $time);
        end else begin
          cur_exp = exp_q.pop_front();
          in_dp   = 1'b1;
          k       = 0;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge HCLK);
    #1;
  endtask

  // Called at posedge+1; returns at posedge+1 after the address phase is taken,
  // leaving HWDATA driven for the data phase so the next call pipelines behind it.
  task automatic issue(input logic w, input logic [2:0] sz, input logic [31:0] a,
                       input logic [31:0] wd, input logic err, input logic [31:0] rd);
    int n;
    hsel   = 1'b1;
    htrans = 2'b10;
    hwrite = w;
    hsize  = sz;
    haddr  = a;
    exp_q.push_back({err, w, rd});
    n = 0;
    do begin
      @(negedge HCLK);
      n++;
    end while (!hready_m && n < 50);
    if (!hready_m) begin
      n_checks++;
      n_fail++;
      $display("FAIL accept_timeout: HREADY stuck low, addr %h", a);
    end
    @(posedge HCLK);
    #1;
    hwdata = w ? wd : 32'h0;
    hsel   = 1'b0;
    htrans = 2'b00;
  endtask

  // ---------------- vectors ----------------
  typedef struct {
    logic        w;
    logic [2:0]  sz;
    logic [31:0] a;
    logic [31:0] wd;
    logic        err;
    logic [31:0] rd;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic w, input logic [2:0] sz, input logic [31:0] a,
                     input logic [31:0] wd, input logic err, input logic [31:0] rd);
    vec_t v;
    v.w = w; v.sz = sz; v.a = a; v.wd = wd; v.err = err; v.rd = rd;
    vecs.push_back(v);
  endtask

  initial begin
    int split;
    // zero-wait-state instance
    add(1, 3'd2, 32'h0000_0010, 32'hDEAD_BEEF, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0010, 32'h0,         0, 32'hDEAD_BEEF);
    add(1, 3'd0, 32'h0000_0011, 32'h1122_AA44, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0010, 32'h0,         0, 32'hDEAD_AAEF);
    add(1, 3'd1, 32'h0000_0012, 32'h1234_5678, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0010, 32'h0,         0, 32'h1234_AAEF);
    add(1, 3'd2, 32'h0000_0000, 32'hCAFE_F00D, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0400, 32'h0,         1, 32'h0);
    add(1, 3'd2, 32'h0000_0002, 32'h1111_1111, 1, 32'h0);
    add(0, 3'd2, 32'h0000_0000, 32'h0,         0, 32'hCAFE_F00D);
    add(1, 3'd1, 32'h0000_0001, 32'h2222_2222, 1, 32'h0);
    add(0, 3'd3, 32'h0000_0020, 32'h0,         1, 32'h0);
    add(1, 3'd2, 32'h0000_03FC, 32'h0BAD_F00D, 0, 32'h0);
    add(0, 3'd2, 32'h0000_03FC, 32'h0,         0, 32'h0BAD_F00D);
    add(1, 3'd0, 32'h0000_03FF, 32'h7766_5544, 0, 32'h0);
    add(0, 3'd2, 32'h0000_03FC, 32'h0,         0, 32'h77AD_F00D);
    add(0, 3'd2, 32'h8000_0010, 32'h0,         1, 32'h0);
    add(1, 3'd1, 32'h0000_0000, 32'h9999_5A5A, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0000, 32'h0,         0, 32'hCAFE_5A5A);
    split = vecs.size();
    // two-wait-state instance
    add(1, 3'd2, 32'h0000_0040, 32'h0123_4567, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0040, 32'h0,         0, 32'h0123_4567);
    add(0, 3'd2, 32'h0000_0040, 32'h0,         0, 32'h0123_4567);
    add(1, 3'd0, 32'h0000_0042, 32'h00C3_0000, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0040, 32'h0,         0, 32'h01C3_4567);
    add(0, 3'd2, 32'h0000_0400, 32'h0,         1, 32'h0);
    add(1, 3'd2, 32'h0000_0044, 32'h55AA_55AA, 0, 32'h0);
    add(0, 3'd2, 32'h0000_0044, 32'h0,         0, 32'h55AA_55AA);

    HRESET = 1'b1; hsel = 1'b0; haddr = '0; htrans = 2'b00; hwrite = 1'b0;
    hsize = 3'd2; hwdata = '0; hready_en = 1'b1; cur = 0;
    idle(3);
    HRESET = 1'b0;
    idle(2);

    for (int i = 0; i < split; i++)
      issue(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].err, vecs[i].rd);
    idle(3);

    // selected but not transferring, or held off by another slave: nothing is taken
    hsel = 1'b1; haddr = 32'h0; hwrite = 1'b1; hsize = 3'd2; hwdata = 32'hFFFF_FFFF;
    htrans = 2'b00;
    idle(2);
    htrans = 2'b01;
    idle(2);
    htrans = 2'b10; hready_en = 1'b0;
    idle(2);
    hsel = 1'b0;
    idle(1);
    hready_en = 1'b1;
    idle(2);
    htrans = 2'b00;
    idle(2);
    issue(0, 3'd2, 32'h0000_0000, 32'h0, 0, 32'hCAFE_5A5A);
    idle(3);

    cur = 2;
    idle(2);
    for (int i = split; i < vecs.size(); i++)
      issue(vecs[i].w, vecs[i].sz, vecs[i].a, vecs[i].wd, vecs[i].err, vecs[i].rd);
    idle(4);

    // reset lands on the second wait cycle of a write; the old word must survive
    issue(1, 3'd2, 32'h0000_0040, 32'hFFFF_FFFF, 0, 32'h0);
    @(posedge HCLK); #1;
    HRESET = 1'b1;
    @(posedge HCLK); #1;
    HRESET = 1'b0;
    @(negedge HCLK);
    check1("rst_ready", ready_m, 1'b1);
    check1("rst_resp", resp_m, 1'b0);
    check("rst_rdata", rdata_m, 32'h0);
    @(posedge HCLK); #1;
    issue(0, 3'd2, 32'h0000_0040, 32'h0, 0, 32'h01C3_4567);
    idle(4);

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
